// File: rtl/xlr8_wdt_if.sv
// ----------------------------------------------------------------------------
// xlr8_wdt_if
//   Register-access bus shared by the XLR8 control registers: the I/O-space
//   path (adr/iore/iowe), the data-memory path (ramadr/ramre/ramwe/dm_sel),
//   write data in, and read data / read-enable back out.
//
//   master : the core side (drives addresses, strobes and write data)
//   slave  : the register block (returns dbus_out and io_out_en)
// ----------------------------------------------------------------------------
interface xlr8_wdt_if;
    logic [5:0] adr;
    logic       iore;
    logic       iowe;
    logic [7:0] ramadr;
    logic       ramre;
    logic       ramwe;
    logic       dm_sel;
    logic [7:0] dbus_in;
    logic [7:0] dbus_out;
    logic       io_out_en;

    modport master (
        output adr, iore, iowe, ramadr, ramre, ramwe, dm_sel, dbus_in,
        input  dbus_out, io_out_en
    );

    modport slave (
        input  adr, iore, iowe, ramadr, ramre, ramwe, dm_sel, dbus_in,
        output dbus_out, io_out_en
    );
endinterface

// File: rtl/xlr8_wdt.sv
// ----------------------------------------------------------------------------
// xlr8_wdt
//   AVR-compatible watchdog timer for the XLR8 core. Counts en128khz pulses
//   against a prescaler-selected limit and, depending on the WDTCSR mode,
//   raises the watchdog interrupt and/or a sticky reset request.
//
// Ports
//   clk          CPU clock, all flops on posedge
//   core_rstn    asynchronous active-low reset
//   en128khz     one-cycle 128 kHz count enable
//   wdr          WDR instruction strobe (kicks the counter)
//   wdrf         MCUSR watchdog-reset flag; forces WDE on while high
//   wdt_irq_ack  core is vectoring to the WDT interrupt
//   bus          register access bus (slave side)
//   wdt_irq      WDIF & WDIE
//   wdt_rst      registered reset request, cleared only by core_rstn
// ----------------------------------------------------------------------------
module xlr8_wdt #(
    parameter logic [7:0] WDTCSR_ADDR = 8'h60
) (
    input  logic           clk,
    input  logic           core_rstn,
    input  logic           en128khz,
    input  logic           wdr,
    input  logic           wdrf,
    input  logic           wdt_irq_ack,
    xlr8_wdt_if.slave      bus,
    output logic           wdt_irq,
    output logic           wdt_rst
);

    // Addresses from 0x60 upward live only in data memory; below that the
    // register is reachable through I/O space at (address - 0x20).
    localparam bit         MEM_MAPPED = (WDTCSR_ADDR >= 8'h60);
    localparam logic [5:0] IO_ADR     = 6'(WDTCSR_ADDR - 8'h20);

    // Timed-sequence window: four cycles after the opening write.
    typedef enum logic [2:0] {
        W_IDLE,
        W_1,
        W_2,
        W_3,
        W_4
    } win_t;

    win_t        win_q;
    win_t        win_nxt;

    logic        wdif;
    logic        wdie;
    logic        wde;
    logic [3:0]  wdp;
    logic [19:0] cnt;

    logic        rd_hit;
    logic        wr_hit;
    logic [7:0]  wr_data;
    logic        wdce;
    logic        timed_wr;
    logic        ewde;
    logic        running;
    logic [3:0]  wdp_eff;
    logic [19:0] lim;
    logic        timeout;
    logic [7:0]  wdtcsr;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    always_comb begin
        if (MEM_MAPPED) begin
            rd_hit = bus.dm_sel && bus.ramre && (bus.ramadr == WDTCSR_ADDR);
            wr_hit = bus.dm_sel && bus.ramwe && (bus.ramadr == WDTCSR_ADDR);
        end else begin
            rd_hit = bus.iore && (bus.adr == IO_ADR);
            wr_hit = bus.iowe && (bus.adr == IO_ADR);
        end
    end

    assign wr_data = bus.dbus_in;

    // ------------------------------------------------------------------
    // Timed-sequence window FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge core_rstn) begin
        if (!core_rstn) begin
            win_q <= W_IDLE;
        end else begin
            win_q <= win_nxt;
        end
    end

    always_comb begin
        win_nxt = win_q;
        case (win_q)
            W_IDLE:  if (wr_hit && wr_data[4] && wr_data[3]) win_nxt = W_1;
            W_1:     win_nxt = wr_hit ? W_IDLE : W_2;
            W_2:     win_nxt = wr_hit ? W_IDLE : W_3;
            W_3:     win_nxt = wr_hit ? W_IDLE : W_4;
            W_4:     win_nxt = W_IDLE;
            default: win_nxt = W_IDLE;
        endcase
    end

    assign wdce     = (win_q != W_IDLE);
    assign timed_wr = wr_hit && wdce;

    // ------------------------------------------------------------------
    // Mode and timeout
    // ------------------------------------------------------------------
    assign ewde    = wde | wdrf;
    assign running = ewde | wdie;
    assign wdp_eff = (wdp > 4'd9) ? 4'd9 : wdp;

    // L = (2048 << WDP) - 1 is simply the low (11 + WDP) bits set; at WDP 9
    // every bit shifts out and L becomes 2^20 - 1.
    assign lim = ~(20'hFFFFF << (5'd11 + {1'b0, wdp_eff}));

    // Exact compare: a counter left above a freshly lowered limit wraps at
    // 2^20 instead of timing out early.
    assign timeout = running && en128khz && !wdr && (cnt == lim);

    // ------------------------------------------------------------------
    // Counter, WDTCSR and reset request
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge core_rstn) begin
        if (!core_rstn) begin
            cnt     <= '0;
            wdif    <= 1'b0;
            wdie    <= 1'b0;
            wde     <= 1'b0;
            wdp     <= '0;
            wdt_rst <= 1'b0;
        end else begin
            if (!running || wdr) begin
                cnt <= '0;
            end else if (en128khz) begin
                cnt <= (cnt == lim) ? '0 : cnt + 20'd1;
            end

            if (wr_hit) begin
                wdie <= wr_data[6];
            end
            if (wdt_irq_ack && ewde) begin
                wdie <= 1'b0;
            end

            // Software clear and acknowledge lose to a simultaneous set.
            if ((wr_hit && wr_data[7]) || wdt_irq_ack) begin
                wdif <= 1'b0;
            end
            if (timeout && wdie) begin
                wdif <= 1'b1;
            end

            if (timed_wr) begin
                wde <= wr_data[3];
                wdp <= {wr_data[5], wr_data[2:0]};
            end else if (wr_hit) begin
                wde <= wde | wr_data[3];
            end

            if (timeout && ewde && !wdie) begin
                wdt_rst <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wdtcsr        = {wdif, wdie, wdp[3], wdce, ewde, wdp[2:0]};
    assign bus.dbus_out  = rd_hit ? wdtcsr : '0;
    assign bus.io_out_en = rd_hit;
    assign wdt_irq       = wdif & wdie;

endmodule

// File: doc/xlr8_wdt.md
# xlr8_wdt

Watchdog timer for the XLR8 core, sitting directly downstream of the clock block. It consumes the `en128khz` enable and the CPU clock. It provides the AVR-compatible WDTCSR register, a `WDR` kick input, interrupt generation and a watchdog reset request to the reset controller. Register access uses the same I/O-bus / data-memory split as the other XLR8 control registers.

## Interface
- `WDTCSR_ADDR`, 8'h60: memory address of WDTCSR. Addresses ≥ 0x60 decode on `ramadr`/`ramre`/`ramwe`/`dm_sel`; lower addresses decode on `adr`/`iore`/`iowe`.
- `clk` in 1: CPU clock; all flops on posedge.
- `core_rstn` in 1: asynchronous, active-low reset.
- `en128khz` in 1: one-`clk` pulse at 128 kHz rate.
- `wdr` in 1: WDR instruction strobe, one cycle.
- `wdrf` in 1: MCUSR watchdog-reset flag (level). While high, WDE reads as 1 and is in effect.
- `wdt_irq_ack` in 1: core vectoring to the WDT interrupt, one cycle.
- `adr` in 6: I/O address.
- `iore` in 1: I/O read strobe.
- `iowe` in 1: I/O write strobe.
- `ramadr` in 8: data-memory address.
- `ramre` in 1: data-memory read strobe.
- `ramwe` in 1: data-memory write strobe.
- `dm_sel` in 1: data-memory select.
- `dbus_in` in 8: write data.
- `dbus_out` out 8: read data. Equals WDTCSR when selected, else 0.
- `io_out_en` out 1: high on a read strobe to WDTCSR.
- `wdt_irq` out 1: equals WDIF & WDIE.
- `wdt_rst` out 1: registered reset request. Stays high until `core_rstn` is asserted.

## Operation
- WDTCSR bits:
  - 7 WDIF, 6 WDIE, 5 WDP3, 4 WDCE, 3 WDE, 2:0 WDP2..0.
  - Reset value 0x00. Reads return WDE | `wdrf` in bit 3.
- WDP = {WDP3, WDP2..0}. Values 10–15 are treated as 9.
- Timeout limit L = (2048 << WDP) − 1. Counter `cnt` is 20 bits.
- Modes, with eWDE = WDE | `wdrf`:
  - Stopped: !eWDE & !WDIE. `cnt` is held at 0.
  - Interrupt: !eWDE & WDIE. Timeout sets WDIF.
  - Reset: eWDE & !WDIE. Timeout sets `wdt_rst`.
  - Interrupt+reset: eWDE & WDIE. Timeout sets WDIF. `wdt_irq_ack` then clears WDIE, so the next timeout is a reset.
- Counting: when running and `en128khz` is high:
  - If `cnt` == L: timeout. `cnt` ← 0.
  - Otherwise `cnt` ← `cnt` + 1.
- `wdr` forces `cnt` ← 0. If `wdr` coincides with a timeout cycle, `wdr` wins and no timeout occurs.
- `wdt_irq_ack` clears WDIF in every mode.
- Writes, always allowed:
  - WDIE ← d[6].
  - WDIF is cleared by writing 1. A hardware set in the same cycle wins.
- Timed sequence:
  - A write with d[4] = 1 and d[3] = 1 sets WDCE, sets WDE, and opens a 4-cycle window. WDP is unchanged by this opening write.
  - A write in any of the next 4 cycles loads WDE ← d[3] and WDP ← {d[5], d[2:0]}, then closes the window (WDCE ← 0).
  - With no such write, WDCE self-clears after 4 cycles.
- Writes outside the window:
  - WDE can only be set (WDE ← WDE | d[3]).
  - WDP is ignored.
  - WDCE is set only by the opening condition.
- A WDP change does not clear `cnt`. If the new L is below `cnt`, the counter counts up to 2^20 − 1, wraps to 0, and continues. No spurious timeout occurs.

## Timing
- `wdt_irq` is combinational from registered bits. WDIF rises on the edge after the timeout cycle.
- `wdt_rst` rises on the edge after the timeout cycle. It is cleared only by `core_rstn`.
- `dbus_out` and `io_out_en` are combinational; read data is the current register value.
- Window counting, for an opening write at cycle N:
  - Writes at N+1 .. N+4 are accepted as timed writes.
  - At N+5 the window is closed and WDCE reads 0.
- If `core_rstn` is asserted mid-window or mid-count, all state clears: registers 0x00, `cnt` 0, window closed, `wdt_rst` 0.

## Test plan
- Reset, then read WDTCSR → 0x00. With `wdrf` = 1, read → 0x08 and the block counts in reset mode.
- Write 0x40 (WDIE, WDP = 0) and run `en128khz` → WDIF set after the 2048th pulse and `wdt_irq` = 1. Then `wdt_irq_ack` → WDIF = 0.
- Write 0x18, then 0x0F at N+2 → WDE = 1, WDP = 7. `wdt_rst` asserts after 262144 pulses. Repeat with the second write at N+5 → ignored; WDP stays 0 and WDE stays 1.
- With WDE = 1, write 0x00 without the timed sequence → WDE stays 1.
- Interrupt+reset mode (0x48 via timed sequence):
  - First timeout → WDIF = 1, `wdt_rst` = 0.
  - `wdt_irq_ack` → WDIE = 0.
  - Second timeout → `wdt_rst` = 1.
- `wdr` in the same cycle as an `en128khz` pulse with `cnt` == 2047 → no timeout and `cnt` = 0. Also: a software WDIF-clear write in the timeout cycle → WDIF = 1.
